// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input sel_t s);
        logic [NREQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8.sv
// 8:1 single-bit data mux, steered by the arbiter's owner index.
module mux8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] din,
    input  sel_t            sel,
    output logic            dout
);

    assign dout = din[sel];

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter/sequencer: grants one of eight requesters the shared
// output channel for up to MAX_BEATS accepted beats, then rotates priority.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] ack,
    output logic [7:0] grant,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic [2:0] out_src,
    output logic       busy
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    // Rotate the request vector so ptr sits at bit 0, take the lowest set
    // bit, then add ptr back to recover the absolute index.
    function automatic sel_t rr_pick(input logic [NREQ-1:0] r, input sel_t p);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        sel_t              k;
        dbl = {r, r} >> p;
        rot = dbl[NREQ-1:0];
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) k = sel_t'(i);
        end
        return p + k;
    endfunction

    arb_state_t       state_reg;
    sel_t             ptr_reg;
    sel_t             owner_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic is_busy;
    logic xfer;
    logic release_now;

    assign is_busy     = (state_reg == BUSY);
    assign out_valid   = is_busy & req[owner_reg];
    // A reset cycle never acknowledges: the in-flight beat is dropped.
    assign xfer        = out_valid & out_ready & ~reset;
    assign release_now = ~req[owner_reg] | (xfer & (cnt_reg == LAST_BEAT));

    assign busy    = is_busy;
    assign out_src = owner_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
            assign grant[gi] = is_busy & (owner_reg == sel_t'(gi));
            assign ack[gi]   = xfer & (owner_reg == sel_t'(gi));
        end
    endgenerate

    mux8 u_mux (
        .din  (d),
        .sel  (owner_reg),
        .dout (out_data)
    );

    // Arbitration FSM: pick in IDLE, count beats and release in BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        owner_reg <= rr_pick(req, ptr_reg);
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_reg <= IDLE;
                        ptr_reg   <= owner_reg + sel_t'(1);
                        cnt_reg   <= '0;
                    end else if (xfer) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
